logic_capture_ts: RTL and testbench

LOGIC_CAPTURE_TS -- requirements
Module: logic_capture_ts

---
 rtl/logic_capture_ts_if.sv | 24 ++
 rtl/logic_capture_ts.sv | 206 ++++++++++++++++++++
 tb/tb_logic_capture_ts.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/logic_capture_ts_if.sv
// -----------------------------------------------------------------------------
// logic_capture_ts_if
// Sample-memory write port of the logic capture block. The capture engine
// drives it as master; the block RAM wrapper (or a bench monitor) is the slave.
//
// Signals:
//   dataout  record {delta timestamp, channel sample}
//   we       write enable, one cycle per record
//   en       memory enable, always equal to we
//   address  write address (record index)
// -----------------------------------------------------------------------------
interface logic_capture_ts_if #(
  parameter int CH_WIDTH   = 8,
  parameter int ADDR_WIDTH = 18,
  parameter int TS_WIDTH   = 16
);
  logic [TS_WIDTH+CH_WIDTH-1:0] dataout;
  logic                         we;
  logic                         en;
  logic [ADDR_WIDTH-1:0]        address;

  modport master (output dataout, we, en, address);
  modport slave  (input  dataout, we, en, address);
endinterface

// File: rtl/logic_capture_ts.sv
// -----------------------------------------------------------------------------
// logic_capture_ts
// Timestamped logic analyser capture engine. Probe inputs are synchronised,
// compared against their previous value, and every cycle in which an enabled
// channel changes produces one {delta, sample} record into block RAM, where
// delta is the number of cycles since the previous record. Long quiet periods
// emit wrap records when delta saturates. Capture stops when the memory is
// full, on host stop, or on reset.
//
// Optional feature: define LOGIC_CAPTURE_TRIGGER_EN to build the ARMED state
// and the rising/falling edge trigger driven by config1. Without it, start
// goes straight to capture, config1 is ignored and status[1] reads 0.
//
// Ports:
//   clk      sole clock, rising edge
//   reset    synchronous active-high reset
//   status   [0] capturing, [1] armed, [2] done/full, [3] stopped by host,
//            [31:8] record count (low 24 bits)
//   control  [0] start, [1] stop (levels, stop has priority)
//   config0  [CH_WIDTH-1:0] channel enable mask
//   config1  [CH_WIDTH-1:0] rise trigger mask, [16+:CH_WIDTH] fall trigger mask
//   datain   asynchronous probe inputs
//   mem      record write port (dataout, we, en, address)
// -----------------------------------------------------------------------------
module logic_capture_ts #(
  parameter int CH_WIDTH   = 8,
  parameter int ADDR_WIDTH = 18,
  parameter int TS_WIDTH   = 16
) (
  input  logic                clk,
  input  logic                reset,
  output logic [31:0]         status,
  input  logic [31:0]         control,
  input  logic [31:0]         config0,
  input  logic [31:0]         config1,
  input  logic [CH_WIDTH-1:0] datain,
  logic_capture_ts_if.master  mem
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARMED,
    ST_CAPTURE,
    ST_DONE
  } state_t;

  state_t                state_reg;
  logic [CH_WIDTH-1:0]   s1_reg;
  logic [CH_WIDTH-1:0]   s2_reg;
  logic [CH_WIDTH-1:0]   prev_reg;
  logic [CH_WIDTH-1:0]   samp_reg;
  logic                  change_reg;
  logic [ADDR_WIDTH:0]   count_reg;
  logic [TS_WIDTH-1:0]   delta_reg;
  logic                  stopped_reg;
  logic                  we_reg;
  logic [TS_WIDTH+CH_WIDTH-1:0] dataout_reg;
  logic [ADDR_WIDTH-1:0] address_reg;

  logic [CH_WIDTH-1:0]   change_bits;
  logic [31:0]           count_ext;
  logic                  armed_flag;
  logic                  unused_bits;

  genvar gi;

  // Per-channel change detect; masked channels are still sampled into the
  // record but can never cause one.
  generate
    for (gi = 0; gi < CH_WIDTH; gi++) begin : g_change
      assign change_bits[gi] = (s2_reg[gi] ^ prev_reg[gi]) & config0[gi];
    end
  endgenerate

`ifdef LOGIC_CAPTURE_TRIGGER_EN
  logic [CH_WIDTH-1:0] rise_mask;
  logic [CH_WIDTH-1:0] fall_mask;
  logic [CH_WIDTH-1:0] edge_hit;
  logic                trig_reg;
  logic                masks_zero;

  assign rise_mask  = config1[CH_WIDTH-1:0];
  assign fall_mask  = config1[16 +: CH_WIDTH];
  assign masks_zero = (rise_mask == '0) && (fall_mask == '0);

  generate
    for (gi = 0; gi < CH_WIDTH; gi++) begin : g_trig
      assign edge_hit[gi] = (s2_reg[gi] & ~prev_reg[gi] & rise_mask[gi]) |
                            (~s2_reg[gi] & prev_reg[gi] & fall_mask[gi]);
    end
  endgenerate

  assign armed_flag = (state_reg == ST_ARMED);
`else
  assign armed_flag = 1'b0;
`endif

  // Decisions (trigger, change, entry record) are all taken from the third
  // pipeline stage (samp/change/trig regs) so the sample written always
  // matches the compare that caused it, and the change that fires a trigger
  // is absorbed into the entry record instead of producing a duplicate.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= ST_IDLE;
      s1_reg      <= '0;
      s2_reg      <= '0;
      prev_reg    <= '0;
      samp_reg    <= '0;
      change_reg  <= 1'b0;
      count_reg   <= '0;
      delta_reg   <= '0;
      stopped_reg <= 1'b0;
      we_reg      <= 1'b0;
      dataout_reg <= '0;
      address_reg <= '0;
`ifdef LOGIC_CAPTURE_TRIGGER_EN
      trig_reg    <= 1'b0;
`endif
    end else begin
      s1_reg     <= datain;
      s2_reg     <= s1_reg;
      prev_reg   <= s2_reg;
      samp_reg   <= s2_reg;
      change_reg <= |change_bits;
`ifdef LOGIC_CAPTURE_TRIGGER_EN
      trig_reg   <= |edge_hit;
`endif
      we_reg     <= 1'b0;

      if (control[1]) begin
        state_reg   <= ST_IDLE;
        stopped_reg <= 1'b1;
      end else begin
        case (state_reg)
          ST_IDLE, ST_DONE: begin
            if (control[0]) begin
              count_reg   <= '0;
              address_reg <= '0;
              delta_reg   <= '0;
              stopped_reg <= 1'b0;
`ifdef LOGIC_CAPTURE_TRIGGER_EN
              state_reg   <= ST_ARMED;
`else
              // Entry record at index 0 with zero delta.
              state_reg   <= ST_CAPTURE;
              we_reg      <= 1'b1;
              dataout_reg <= {{TS_WIDTH{1'b0}}, samp_reg};
              count_reg   <= (ADDR_WIDTH+1)'(1);
              delta_reg   <= TS_WIDTH'(1);
`endif
            end
          end
`ifdef LOGIC_CAPTURE_TRIGGER_EN
          ST_ARMED: begin
            // With no trigger channels selected, fire on the next cycle.
            if (trig_reg || masks_zero) begin
              state_reg   <= ST_CAPTURE;
              we_reg      <= 1'b1;
              dataout_reg <= {{TS_WIDTH{1'b0}}, samp_reg};
              address_reg <= '0;
              count_reg   <= (ADDR_WIDTH+1)'(1);
              delta_reg   <= TS_WIDTH'(1);
            end
          end
`endif
          ST_CAPTURE: begin
            // A saturated delta forces a wrap record; if a change coincides
            // it is the same single record.
            if (change_reg || (&delta_reg)) begin
              we_reg      <= 1'b1;
              dataout_reg <= {delta_reg, samp_reg};
              address_reg <= count_reg[ADDR_WIDTH-1:0];
              count_reg   <= count_reg + (ADDR_WIDTH+1)'(1);
              delta_reg   <= TS_WIDTH'(1);
              // Last slot written: count MSB sets, capture halts and the
              // address is left on the final slot.
              if (&count_reg[ADDR_WIDTH-1:0]) begin
                state_reg <= ST_DONE;
              end
            end else begin
              delta_reg <= delta_reg + TS_WIDTH'(1);
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign count_ext = 32'(count_reg);

  assign status = {count_ext[23:0], 4'b0000, stopped_reg,
                   (state_reg == ST_DONE), armed_flag,
                   (state_reg == ST_CAPTURE)};

  assign mem.dataout = dataout_reg;
  assign mem.we      = we_reg;
  assign mem.en      = we_reg;
  assign mem.address = address_reg;

  // Register bits the function does not use (upper control/config bits,
  // count bits beyond the status field).
  assign unused_bits = ^{control, config0, config1, count_ext};

endmodule

// File: tb/tb_logic_capture_ts.sv
// -----------------------------------------------------------------------------
// tb_logic_capture_ts
// Directed bench for logic_capture_ts. Three instances share all inputs:
//   main  default parameters
//   ts    TS_WIDTH=4   (delta wrap)
//   aw    ADDR_WIDTH=3 (memory full)
// A monitor per instance logs every write as one transaction line and queues
// it; each scenario checks the queues and status against hand-computed values.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_logic_capture_ts;

`ifdef LOGIC_CAPTURE_TRIGGER_EN
  localparam int ARM_LAT = 1;   // extra cycle spent in ARMED with zero masks
`else
  localparam int ARM_LAT = 0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] control;
  logic [31:0] config0;
  logic [31:0] config1;
  logic [7:0]  datain;
  logic [31:0] status_main;
  logic [31:0] status_ts;
  logic [31:0] status_aw;

  always #5 clk = ~clk;

  logic_capture_ts_if #(.CH_WIDTH(8), .ADDR_WIDTH(18), .TS_WIDTH(16)) bus_main ();
  logic_capture_ts_if #(.CH_WIDTH(8), .ADDR_WIDTH(18), .TS_WIDTH(4))  bus_ts ();
  logic_capture_ts_if #(.CH_WIDTH(8), .ADDR_WIDTH(3),  .TS_WIDTH(16)) bus_aw ();

  logic_capture_ts #(.CH_WIDTH(8), .ADDR_WIDTH(18), .TS_WIDTH(16)) dut_main (
    .clk(clk), .reset(reset), .status(status_main), .control(control),
    .config0(config0), .config1(config1), .datain(datain), .mem(bus_main)
  );

  logic_capture_ts #(.CH_WIDTH(8), .ADDR_WIDTH(18), .TS_WIDTH(4)) dut_ts (
    .clk(clk), .reset(reset), .status(status_ts), .control(control),
    .config0(config0), .config1(config1), .datain(datain), .mem(bus_ts)
  );

  logic_capture_ts #(.CH_WIDTH(8), .ADDR_WIDTH(3), .TS_WIDTH(16)) dut_aw (
    .clk(clk), .reset(reset), .status(status_aw), .control(control),
    .config0(config0), .config1(config1), .datain(datain), .mem(bus_aw)
  );

  typedef struct {
    logic [31:0] data;
    logic [31:0] addr;
    int          cyc;
  } rec_t;

  rec_t q_main[$];
  rec_t q_ts[$];
  rec_t q_aw[$];

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Record monitor, sampled 1 ns after the edge that produced the write.
  always begin
    @(posedge clk);
    #1;
    if (bus_main.we) begin
      q_main.push_back('{32'(bus_main.dataout), 32'(bus_main.address), cyc});
      $display("rec main cyc=%0d addr=%0d data=%h", cyc, bus_main.address, bus_main.dataout);
    end
    if (bus_ts.we) begin
      q_ts.push_back('{32'(bus_ts.dataout), 32'(bus_ts.address), cyc});
      $display("rec ts   cyc=%0d addr=%0d data=%h", cyc, bus_ts.address, bus_ts.dataout);
    end
    if (bus_aw.we) begin
      q_aw.push_back('{32'(bus_aw.dataout), 32'(bus_aw.address), cyc});
      $display("rec aw   cyc=%0d addr=%0d data=%h", cyc, bus_aw.address, bus_aw.dataout);
    end
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  // Pulse start for one edge; returns the edge number of the start edge and
  // leaves the caller on the following falling edge.
  task automatic start_capture(output int s);
    @(negedge clk);
    control = 32'h1;
    @(posedge clk);
    #1;
    s = cyc;
    @(negedge clk);
    control = 32'h0;
  endtask

  task automatic stop_all();
    @(negedge clk);
    control = 32'h2;
    @(negedge clk);
    control = 32'h0;
  endtask

  task automatic clear_queues();
    q_main.delete();
    q_ts.delete();
    q_aw.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s;
    reset   = 1'b1;
    control = 32'h0;
    config0 = 32'hFF;
    config1 = 32'h0;
    datain  = 8'hA5;

    // ---------------- reset state ----------------
    repeat (3) @(negedge clk);
    check_val("rst_status",  64'(status_main),      64'h0);
    check_val("rst_dataout", 64'(bus_main.dataout), 64'h0);
    check_val("rst_address", 64'(bus_main.address), 64'h0);
    check_val("rst_we",      64'(bus_main.we),      64'h0);
    check_val("rst_en",      64'(bus_main.en),      64'h0);
    check_val("rst_status_aw", 64'(status_aw),      64'h0);
    datain = 8'h00;
    @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    check_val("idle_status", 64'(status_main), 64'h0);
    check_val("idle_nowrite", 64'(q_main.size()), 64'd0);

    // ---------------- basic record and latency ----------------
    clear_queues();
    start_capture(s);
    repeat (ARM_LAT) @(negedge clk);
    check_val("t1_capturing", 64'(status_main), 64'h101);
    repeat (9 - ARM_LAT) @(negedge clk);
    datain = 8'h01;                      // settled before edge s+10
    repeat (6) @(negedge clk);
    check_val("t1_nrec", 64'(q_main.size()), 64'd2);
    if (q_main.size() >= 2) begin
      check_val("t1_rec0_data", 64'(q_main[0].data), 64'h0);
      check_val("t1_rec0_addr", 64'(q_main[0].addr), 64'd0);
      check_val("t1_rec0_cyc",  64'(q_main[0].cyc),  64'(s + ARM_LAT));
      check_val("t1_rec1_data", 64'(q_main[1].data), 64'({16'(13 - ARM_LAT), 8'h01}));
      check_val("t1_rec1_addr", 64'(q_main[1].addr), 64'd1);
      check_val("t1_rec1_cyc",  64'(q_main[1].cyc),  64'(s + 13));
    end
    check_val("t1_count", 64'(status_main), 64'h201);

    // ---------------- host stop ----------------
    control = 32'h3;
    @(negedge clk);
    control = 32'h0;
    check_val("t2_stop_status", 64'(status_main), 64'h208);
    check_val("t2_stop_we", 64'(bus_main.we), 64'h0);
    control = 32'h3;                     // stop beats start while idle
    @(negedge clk);
    control = 32'h0;
    check_val("t2_stopwins_status", 64'(status_main), 64'h208);
    check_val("t2_stopwins_nrec", 64'(q_main.size()), 64'd2);

    // ---------------- delta wrap (TS_WIDTH=4) ----------------
    datain = 8'h5A;
    repeat (6) @(negedge clk);
    clear_queues();
    start_capture(s);
    repeat (33) @(negedge clk);
    check_val("t3_main_status", 64'(status_main), 64'h101);
    check_val("t3_ts_nrec", 64'(q_ts.size()), 64'd3);
    if (q_ts.size() >= 3) begin
      check_val("t3_rec0_data", 64'(q_ts[0].data), 64'h05A);
      check_val("t3_rec1_data", 64'(q_ts[1].data), 64'hF5A);
      check_val("t3_rec2_data", 64'(q_ts[2].data), 64'hF5A);
      check_val("t3_rec1_cyc",  64'(q_ts[1].cyc),  64'(s + ARM_LAT + 15));
      check_val("t3_rec2_cyc",  64'(q_ts[2].cyc),  64'(s + ARM_LAT + 30));
      check_val("t3_rec2_addr", 64'(q_ts[2].addr), 64'd2);
    end

    // ---------------- memory full (ADDR_WIDTH=3) ----------------
    stop_all();
    clear_queues();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      datain  = ~datain;
      control = (i == 5) ? 32'h1 : 32'h0;
    end
    check_val("t4_nrec", 64'(q_aw.size()), 64'd8);
    for (int j = 0; j < 8; j++) begin
      if (j < q_aw.size()) begin
        check_val($sformatf("t4_addr%0d", j), 64'(q_aw[j].addr), 64'(j));
        check_val($sformatf("t4_cyc%0d", j), 64'(q_aw[j].cyc), 64'(q_aw[0].cyc + j));
      end
    end
    check_val("t4_status", 64'(status_aw), 64'h804);
    check_val("t4_address_hold", 64'(bus_aw.address), 64'd7);

    // ---------------- masked channel ----------------
    stop_all();
    datain  = 8'h00;
    config0 = 32'h0F;
    repeat (5) @(negedge clk);
    clear_queues();
    start_capture(s);
    repeat (2) @(negedge clk);
    datain = 8'h80;                      // masked bit only: no record
    repeat (4) @(negedge clk);
    datain = 8'h81;                      // settled before edge s+7
    repeat (6) @(negedge clk);
    check_val("t5_nrec", 64'(q_main.size()), 64'd2);
    if (q_main.size() >= 2) begin
      check_val("t5_rec0_data", 64'(q_main[0].data), 64'h0);
      check_val("t5_rec1_data", 64'(q_main[1].data), 64'({16'(10 - ARM_LAT), 8'h81}));
    end

    // ---------------- trigger ----------------
    stop_all();
    datain  = 8'h00;
    config0 = 32'hFF;
    config1 = 32'h04;                    // rise on bit2
    repeat (5) @(negedge clk);
    clear_queues();
    start_capture(s);
`ifdef LOGIC_CAPTURE_TRIGGER_EN
    check_val("t6_armed", 64'(status_main), 64'h002);
    datain = 8'h01;
    repeat (3) @(negedge clk);
    datain = 8'h00;
    repeat (3) @(negedge clk);
    datain = 8'h01;
    repeat (5) @(negedge clk);
    check_val("t6_still_armed", 64'(status_main), 64'h002);
    check_val("t6_nowrite", 64'(q_main.size()), 64'd0);
    datain = 8'h05;
    repeat (3) @(negedge clk);
    check_val("t6_armed_late", 64'(status_main), 64'h002);
    check_val("t6_nowrite_late", 64'(q_main.size()), 64'd0);
    repeat (2) @(negedge clk);
    check_val("t6_nrec", 64'(q_main.size()), 64'd1);
    if (q_main.size() >= 1) begin
      check_val("t6_rec0_data", 64'(q_main[0].data), 64'h0005);
    end
    check_val("t6_capturing", 64'(status_main), 64'h101);
`else
    check_val("t6_no_arm", 64'(status_main), 64'h101);
    check_val("t6_nrec", 64'(q_main.size()), 64'd1);
    if (q_main.size() >= 1) begin
      check_val("t6_rec0_data", 64'(q_main[0].data), 64'h0000);
    end
`endif

    // ---------------- reset mid-capture ----------------
    stop_all();
    config1 = 32'h0;
    clear_queues();
    start_capture(s);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      datain = ~datain;
    end
    check_val("t7_pre_capturing", 64'(status_main[0]), 64'h1);
    check_val("t7_pre_written", 64'(q_main.size() > 0), 64'h1);
    @(negedge clk);
    datain = ~datain;
    reset  = 1'b1;
    @(posedge clk);
    #1;
    check_val("t7_rst_we",      64'(bus_main.we),      64'h0);
    check_val("t7_rst_en",      64'(bus_main.en),      64'h0);
    check_val("t7_rst_status",  64'(status_main),      64'h0);
    check_val("t7_rst_address", 64'(bus_main.address), 64'h0);
    check_val("t7_rst_dataout", 64'(bus_main.dataout), 64'h0);
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check_val("t7_after_status", 64'(status_main), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
